// File: rtl/result_serializer_pkg.sv
// Shared definitions for the result serializer and its operand-loader sibling.
package outputdata_pkg;

  // FSM states shared by the loader/serializer pair
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } state_t;

  // 7-seg display tag prefixes: operands A/B and the result
  localparam logic [3:0] TAG_A = 4'hA;
  localparam logic [3:0] TAG_B = 4'hB;
  localparam logic [3:0] TAG_R = 4'hC;

  // Special-case codes carried alongside a result word
  localparam logic [1:0] FLAG_NORM = 2'b00;
  localparam logic [1:0] FLAG_ZERO = 2'b01;
  localparam logic [1:0] FLAG_INF  = 2'b10;
  localparam logic [1:0] FLAG_NAN  = 2'b11;

  // Byte number 0 marks the header byte on the display
  localparam logic [3:0] HDR_NUM = 4'h0;

  // Build a result display tag from a 1-based byte number
  function automatic logic [7:0] result_tag(input logic [3:0] num);
    return {TAG_R, num};
  endfunction

endpackage

// File: rtl/result_serializer_if.sv
// Word-in / byte-out handshake bundle for the result serializer.
// master: serializer side, slave: upstream producer plus downstream consumer.
interface result_serializer_if #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned BYTE_W = 8
);

  logic                     word_valid;
  logic                     word_ready;
  logic [NBYTES*BYTE_W-1:0] word_data;
  logic [1:0]               word_flags;
  logic                     byte_valid;
  logic                     byte_ready;
  logic [BYTE_W-1:0]        byte_data;
  logic [7:0]               byte_tag;
  logic                     byte_last;
  logic                     busy;
  logic                     done;

  modport master (
    input  word_valid, word_data, word_flags, byte_ready,
    output word_ready, byte_valid, byte_data, byte_tag, byte_last, busy, done
  );

  modport slave (
    output word_valid, word_data, word_flags, byte_ready,
    input  word_ready, byte_valid, byte_data, byte_tag, byte_last, busy, done
  );

endinterface

// File: rtl/result_serializer.sv
// Result serializer: takes one result word and streams it out LSB byte first,
// each byte tagged for the 7-seg display path.
// Optional RESULT_SERIALIZER_HEADER_EN: prepend a header byte carrying the flags.
module result_serializer
  import outputdata_pkg::*;
#(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned BYTE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  result_serializer_if.master bus
);

  localparam int unsigned WORD_W = NBYTES * BYTE_W;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;

  logic                word_ready_q, word_ready_d;
  logic                busy_q, busy_d;
  logic                byte_valid_q, byte_valid_d;
  logic [BYTE_W-1:0]   byte_data_q, byte_data_d;
  logic [7:0]          byte_tag_q, byte_tag_d;
  logic                byte_last_q, byte_last_d;
  logic                done_q, done_d;

  logic                accept;
  logic                hs;
  logic                is_last;

`ifdef RESULT_SERIALIZER_HEADER_EN
  logic [1:0]          flags_q, flags_d;
`else
  logic                unused_flags;
  assign unused_flags = ^bus.word_flags;
`endif

  assign accept  = word_ready_q && bus.word_valid;
  assign hs      = byte_valid_q && bus.byte_ready;
  assign is_last = (cnt_q == LAST_CNT);

  // State, held word and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      word_q       <= '0;
      word_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_tag_q   <= '0;
      byte_last_q  <= 1'b0;
      done_q       <= 1'b0;
`ifdef RESULT_SERIALIZER_HEADER_EN
      flags_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_ready_q <= word_ready_d;
      busy_q       <= busy_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_tag_q   <= byte_tag_d;
      byte_last_q  <= byte_last_d;
      done_q       <= done_d;
`ifdef RESULT_SERIALIZER_HEADER_EN
      flags_q      <= flags_d;
`endif
    end
  end

  // Next state, byte counter and word capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
`ifdef RESULT_SERIALIZER_HEADER_EN
    flags_d = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d = bus.word_data;
          cnt_d  = '0;
`ifdef RESULT_SERIALIZER_HEADER_EN
          flags_d = bus.word_flags;
          state_d = HDR;
`else
          state_d = SEND;
`endif
        end
      end
      HDR: begin
        if (hs) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (hs) begin
          if (is_last) state_d = IDLE;
          else         cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so they register cleanly
  always_comb begin
    word_ready_d = 1'b0;
    busy_d       = 1'b0;
    byte_valid_d = 1'b0;
    byte_data_d  = '0;
    byte_tag_d   = '0;
    byte_last_d  = 1'b0;
    done_d       = (state_q == SEND) && hs && is_last;
    case (state_d)
      IDLE: word_ready_d = 1'b1;
      HDR: begin
        busy_d       = 1'b1;
        byte_valid_d = 1'b1;
        byte_tag_d   = result_tag(HDR_NUM);
`ifdef RESULT_SERIALIZER_HEADER_EN
        byte_data_d  = BYTE_W'(flags_d);
`endif
      end
      SEND: begin
        busy_d       = 1'b1;
        byte_valid_d = 1'b1;
        byte_data_d  = BYTE_W'(word_d >> (int'(cnt_d) * BYTE_W));
        byte_tag_d   = result_tag(4'(cnt_d) + 4'd1);
        byte_last_d  = (cnt_d == LAST_CNT);
      end
      default: word_ready_d = 1'b0;
    endcase
  end

  assign bus.word_ready = word_ready_q;
  assign bus.busy       = busy_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_tag   = byte_tag_q;
  assign bus.byte_last  = byte_last_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: directed scenarios plus random traffic against a
// byte-queue reference model and a word reassembling scoreboard.
module tb_result_serializer;

  localparam int unsigned NB = 4;
  localparam int unsigned BW = 8;
`ifdef RESULT_SERIALIZER_HEADER_EN
  localparam int HDR_EN = 1;
`else
  localparam int HDR_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  result_serializer_if #(.NBYTES(NB), .BYTE_W(BW)) bus ();

  result_serializer #(.NBYTES(NB), .BYTE_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] tag;
    logic       last;
    bit         hdr;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] word_q[$];
  logic [7:0]  log_q[$];
  logic [31:0] asm_word;
  bit          done_exp = 1'b0;
  int          done_cnt = 0;
  int          words_done = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected byte stream of one accepted word
  task automatic model_accept(input logic [31:0] w, input logic [1:0] f);
    beat_t b;
    if (HDR_EN != 0) begin
      b.data = {6'b0, f};
      b.tag  = 8'hC0;
      b.last = 1'b0;
      b.hdr  = 1'b1;
      exp_q.push_back(b);
    end
    for (int k = 0; k < int'(NB); k++) begin
      b.data = 8'(w >> (8 * k));
      b.tag  = 8'hC1 + 8'(k);
      b.last = (k == int'(NB) - 1);
      b.hdr  = 1'b0;
      exp_q.push_back(b);
    end
    word_q.push_back(w);
  endtask

  // Reference model and scoreboard, evaluated mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      word_q.delete();
      done_exp = 1'b0;
      asm_word = '0;
    end else begin
      check("word_ready", bus.word_ready, exp_q.size() == 0);
      check("busy",       bus.busy,       exp_q.size() != 0);
      check("byte_valid", bus.byte_valid, exp_q.size() != 0);
      check("done",       bus.done,       done_exp);
      if (bus.done === 1'b1) done_cnt++;
      done_exp = 1'b0;
      if (exp_q.size() != 0) begin
        check("byte_data", bus.byte_data, exp_q[0].data);
        check("byte_tag",  bus.byte_tag,  exp_q[0].tag);
        check("byte_last", bus.byte_last, exp_q[0].last);
        if (bus.byte_ready) begin
          log_q.push_back(bus.byte_data);
          if (!exp_q[0].hdr)
            asm_word[(int'(exp_q[0].tag[3:0]) - 1) * 8 +: 8] = bus.byte_data;
          if (exp_q[0].last) begin
            check("word", asm_word, word_q.pop_front());
            words_done++;
            done_exp = 1'b1;
          end
          void'(exp_q.pop_front());
        end
      end else if (bus.word_valid) begin
        model_accept(bus.word_data, bus.word_flags);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until it is taken; returns one cycle after acceptance
  task automatic offer(input logic [31:0] w, input logic [1:0] f);
    int budget;
    budget = 0;
    bus.word_valid = 1'b1;
    bus.word_data  = w;
    bus.word_flags = f;
    while (!bus.word_ready && budget < 200) begin
      tick();
      budget++;
    end
    check("offer_accept", budget < 200, 1'b1);
    tick();
    bus.word_valid = 1'b0;
  endtask

  // Count cycles from acceptance until word_ready returns
  task automatic wait_ready(output int n);
    n = 1;
    while (!bus.word_ready && n < 500) begin
      tick();
      n++;
    end
    check("ready_return", n < 500, 1'b1);
  endtask

  task automatic check_log(input string tag, input logic [31:0] w, input logic [7:0] hdr_byte);
    logic [7:0] e;
    check({tag, "_len"}, log_q.size(), NB + HDR_EN);
    if (HDR_EN != 0 && log_q.size() > 0) check({tag, "_hdr"}, log_q[0], hdr_byte);
    for (int k = 0; k < int'(NB); k++) begin
      e = 8'(w >> (8 * k));
      if (k + HDR_EN < log_q.size()) check({tag, "_byte"}, log_q[k + HDR_EN], e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    int cyc;
    bit took;
    logic [7:0] basic_b [4];

    rst = 1'b1;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.word_flags = '0;
    bus.byte_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_word_ready", bus.word_ready, 1'b1);
    check("rst_byte_valid", bus.byte_valid, 1'b0);
    check("rst_byte_data",  bus.byte_data,  8'h00);
    check("rst_byte_tag",   bus.byte_tag,   8'h00);
    check("rst_byte_last",  bus.byte_last,  1'b0);
    check("rst_busy",       bus.busy,       1'b0);
    check("rst_done",       bus.done,       1'b0);

    // Basic transfer at full rate
    log_q.delete();
    bus.byte_ready = 1'b1;
    offer(32'h3F80_0000, 2'b00);
    wait_ready(n);
    check("basic_latency", n, NB + 1 + HDR_EN);
    check("basic_done_pulse", bus.done, 1'b1);
    basic_b = '{8'h00, 8'h00, 8'h80, 8'h3F};
    for (int k = 0; k < 4; k++)
      if (k + HDR_EN < log_q.size()) check("basic_seq", log_q[k + HDR_EN], basic_b[k]);
    tick();
    check("basic_done_once", bus.done, 1'b0);

    // Backpressure: three stall cycles in front of every byte
    log_q.delete();
    bus.byte_ready = 1'b0;
    offer(32'hDEAD_BEEF, 2'b01);
    for (int k = 0; k < int'(NB) + HDR_EN; k++) begin
      bus.byte_ready = 1'b0;
      repeat (3) tick();
      bus.byte_ready = 1'b1;
      tick();
    end
    bus.byte_ready = 1'b0;
    wait_ready(n);
    check_log("bp", 32'hDEAD_BEEF, 8'h01);

    // No overlap: second word offered while the first is streaming
    bus.byte_ready = 1'b1;
    offer(32'h0BAD_F00D, 2'b10);
    bus.word_valid = 1'b1;
    bus.word_data  = 32'h1234_5678;
    bus.word_flags = 2'b00;
    check("overlap_blocked", bus.word_ready, 1'b0);
    wait_ready(n);
    check("overlap_done", bus.done, 1'b1);
    tick();
    bus.word_valid = 1'b0;
    log_q.delete();
    check("overlap_taken", bus.word_ready, 1'b0);
    wait_ready(n);
    check_log("overlap", 32'h1234_5678, 8'h00);

    // Reset after the second byte handshake
    tick();
    bus.byte_ready = 1'b1;
    offer(32'hA5C3_9617, 2'b11);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", bus.byte_valid, 1'b0);
    check("mid_rst_busy",  bus.busy,       1'b0);
    check("mid_rst_ready", bus.word_ready, 1'b1);
    check("mid_rst_done",  bus.done,       1'b0);
    tick();
    check("mid_rst_nodone", bus.done, 1'b0);
    log_q.delete();
    offer(32'h0102_0304, 2'b00);
    wait_ready(n);
    check_log("after_rst", 32'h0102_0304, 8'h00);

`ifdef RESULT_SERIALIZER_HEADER_EN
    // Header byte carries the flags ahead of the data bytes
    tick();
    log_q.delete();
    offer(32'h7FC0_0000, 2'b11);
    wait_ready(n);
    check("hdr_latency", n, NB + 2);
    check_log("hdr", 32'h7FC0_0000, 8'h03);
`endif

    // Random traffic with random downstream readiness
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 30000) begin
      bus.byte_ready = ($urandom_range(0, 3) != 0);
      if (!bus.word_valid && $urandom_range(0, 2) != 0) begin
        bus.word_valid = 1'b1;
        bus.word_data  = $urandom;
        bus.word_flags = 2'($urandom_range(0, 3));
      end else if (bus.word_valid && !bus.word_ready && $urandom_range(0, 7) == 0) begin
        bus.word_valid = 1'b0;
      end
      took = bus.word_valid && bus.word_ready;
      tick();
      cyc++;
      if (took) begin
        acc++;
        bus.word_valid = 1'b0;
      end
    end
    check("random_words", acc, 1000);
    bus.word_valid = 1'b0;
    bus.byte_ready = 1'b1;
    wait_ready(n);
    tick();
    tick();
    check("model_drained", exp_q.size(), 0);
    check("done_count", done_cnt, words_done);
    check("words_done", words_done, 1005 + HDR_EN);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Output-side counterpart of the byte-wise operand loader.
- Accepts one 32-bit result word plus 2-bit special flags over a valid/ready handshake.
- Streams the word out as NBYTES bytes, LSB byte first, on a byte-wide valid/ready handshake.
- Each byte carries a 7-seg display tag, so the same display path can show "C1..C4" alongside each byte.

Parameters:
- NBYTES, 4, number of bytes per word (word width = NBYTES*BYTE_W); legal range 2..7.
- BYTE_W, 8, width of each output byte.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- word_valid  input  1  upstream has a result word.
- word_ready  output  1  block can accept a word this cycle.
- word_data  input  NBYTES*BYTE_W  result word.
- word_flags  input  2  special-case code (00 normal, 01 zero, 10 inf, 11 NaN).
- byte_valid  output  1  byte_data is valid.
- byte_ready  input  1  downstream accepts byte this cycle.
- byte_data  output  BYTE_W  current byte.
- byte_tag  output  8  display tag {4'hC, 1-based byte number}; header byte uses {4'hC, 4'h0}.
- byte_last  output  1  current byte is the final byte of the word.
- busy  output  1  a word is held and being sent.
- done  output  1  one-cycle pulse after the last byte handshake.

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE, word_ready=1, byte_valid=0, byte_data=0, byte_tag=0, byte_last=0, busy=0, done=0, internal counter=0, held word/flags=0.
- Reset mid-transfer: abandons the word immediately; no done pulse is produced.
- IDLE:
  - word_ready=1.
  - On word_valid && word_ready, capture word_data and word_flags, set cnt=0, and go to SEND (or HDR when the optional feature is enabled).
- SEND:
  - word_ready=0, busy=1, byte_valid=1.
  - byte_data = held[cnt*BYTE_W +: BYTE_W]; byte_tag = {4'hC, cnt+1}; byte_last = (cnt==NBYTES-1).
  - Handshake = byte_valid && byte_ready.
  - On handshake with !byte_last: cnt increments and the next byte appears the next cycle.
  - On handshake with byte_last: go to IDLE and pulse done=1 for exactly one cycle (the first cycle back in IDLE).
- Stall rule: while byte_valid && !byte_ready, byte_data, byte_tag and byte_last hold stable.
- Latency:
  - First byte_valid appears 1 cycle after word acceptance.
  - With byte_ready held high, one byte per cycle.
  - A word takes NBYTES+1 cycles from acceptance back to word_ready=1.
- No overlap: word_ready stays 0 from acceptance until back in IDLE, so a new word offered during SEND is not taken.
- word_valid dropped during SEND has no effect.
- byte_ready asserted while byte_valid=0 is ignored.
- Counter: width clog2(NBYTES+1) bits; never exceeds NBYTES-1 in SEND; cleared on acceptance.
- Flags are held, not decoded; they appear only in the header (optional feature).

Optional Feature:
- Macro: RESULT_SERIALIZER_HEADER_EN.
- Defined: an extra HDR state precedes SEND.
  - HDR emits byte_data = {6'b0, flags_held} (zero-extended to BYTE_W), byte_tag = 8'hC0, byte_last=0.
  - After the HDR handshake, the block goes to SEND with cnt=0.
  - A word then takes NBYTES+2 cycles from acceptance back to word_ready=1 at full rate.
- Undefined: the HDR state is absent and word_flags is unused.

Decomposition:
- Shared package outputdata_pkg holds:
  - enum state_t {IDLE, HDR, SEND}, logic [1:0] encoding;
  - localparam TAG_A=4'hA, TAG_B=4'hB, TAG_R=4'hC, also used by the operand loader;
  - flag codes FLAG_NORM/ZERO/INF/NAN.
- No sub-module is needed: byte select, counter and FSM sit in one module.
- The display tag feeds the existing peripheral_deco7seg instances externally.

Test Plan:
- Basic transfer: reset, offer word 32'h3F80_0000, hold byte_ready=1 -> bytes 00,00,80,3F with tags C1,C2,C3,C4; byte_last on the 4th byte; done one cycle later; word_ready back high.
- Backpressure: word 32'hDEAD_BEEF, byte_ready low 3 cycles at each byte -> byte_data EF/BE/AD/DE held stable during stalls; no byte skipped or duplicated.
- No overlap: offer a second word 32'h1234_5678 during SEND -> not accepted (word_ready=0); accepted 1 cycle after done; emits 78,56,34,12.
- Reset mid-operation: rst pulsed after the 2nd byte handshake -> next cycle byte_valid=0, busy=0, word_ready=1, no done; the next word starts again from byte 1.
- Header (macro defined): word_flags=2'b11, word 32'h7FC0_0000 -> first byte 8'h03 with tag C0, then 00,00,C0,7F; 6 cycles from acceptance back to word_ready=1 at full rate.
- Random ready: 1000 random words with random byte_ready -> a scoreboard reassembles each word from the byte stream and matches every word; the done count equals the word count.
